// File: rtl/vpm_pipeline.sv
// ============================================================================
// vpm_pipeline : fixed-latency data + control register pipeline built from a
//                generic synchronous-reset register primitive.
// Optional: VPM_PIPELINE_DATA_GATE_EN (data stages load only on control = 1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module vpm_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

module vpm_pipeline #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  icontrol,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ocontrol
);

  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_in;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_d;
  logic [STAGES-1:0]                 ctrl_q;
  logic [STAGES-1:0]                 ctrl_in;

  assign data_in[0] = idata;
  assign ctrl_in[0] = icontrol;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign data_in[k] = data_q[k-1];
    assign ctrl_in[k] = ctrl_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
`ifdef VPM_PIPELINE_DATA_GATE_EN
    // Hold the last valid word while the control bit entering this stage is 0.
    assign data_d[k] = ctrl_in[k] ? data_in[k] : data_q[k];
`else
    assign data_d[k] = data_in[k];
`endif

    // The reset port is active-high despite its _n name.
    vpm_reg #(.WIDTH(DATA_WIDTH)) u_data (
      .clk (clk),
      .rst (rst_n),
      .d   (data_d[k]),
      .q   (data_q[k])
    );

    vpm_reg #(.WIDTH(1)) u_ctrl (
      .clk (clk),
      .rst (rst_n),
      .d   (ctrl_in[k]),
      .q   (ctrl_q[k])
    );
  end

  assign odata    = data_q[STAGES-1];
  assign ocontrol = ctrl_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_vpm_pipeline.sv
// ============================================================================
// tb_vpm_pipeline : scoreboard bench for the 4-stage and 1-stage builds.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vpm_pipeline;

`ifdef VPM_PIPELINE_DATA_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] idata;
  logic       icontrol;
  logic [7:0] odata4, odata1;
  logic       ocontrol4, ocontrol1;

  logic [8:0] exp4_q[$];
  logic [8:0] exp1_q[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  done   = 1'b0;
  bit  mon_done = 1'b0;

  always #5 clk = ~clk;

  vpm_pipeline #(.DATA_WIDTH(8), .STAGES(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .idata    (idata),
    .icontrol (icontrol),
    .odata    (odata4),
    .ocontrol (ocontrol4)
  );

  vpm_pipeline #(.DATA_WIDTH(8), .STAGES(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .idata    (idata),
    .icontrol (icontrol),
    .odata    (odata1),
    .ocontrol (ocontrol1)
  );

  // Apply one input vector and queue the outputs expected right after the
  // edge that samples it, for both the 4-stage and 1-stage instances.
  task automatic step(input logic r, input logic [7:0] d, input logic c,
                      input logic [7:0] ed4, input logic ec4,
                      input logic [7:0] ed1, input logic ec1);
    @(negedge clk);
    rst_n    = r;
    idata    = d;
    icontrol = c;
    exp4_q.push_back({ec4, ed4});
    exp1_q.push_back({ec1, ed1});
  endtask

  initial begin
    logic [7:0] jb;
    logic [7:0] ib;
    rst_n    = 1'b1;
    idata    = 8'h00;
    icontrol = 1'b0;

    // Reset hold with non-zero inputs.
    for (int n = 0; n < 3; n++)
      step(1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

    // Counter stream through the wrap, with a control bubble on word 0x10.
    for (int i = 0; i <= 260; i++) begin
      ib = 8'(i);
      if (i < 3) begin
        jb = 8'h00;
        step(1'b0, ib, (i != 16), 8'h00, 1'b0,
             ib, 1'b1);
      end else begin
        jb = 8'(i - 3);
        step(1'b0, ib, (i != 16),
             (GATE && (i - 3) == 16) ? 8'h0F : jb, ((i - 3) != 16),
             (GATE && i == 16) ? 8'h0F : ib, (i != 16));
      end
    end

    // Words 0x20..0x22 enter while the stream tail (2,3,4) drains out.
    step(1'b0, 8'h20, 1'b1, 8'h02, 1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h21, 1'b1, 8'h03, 1'b1, 8'h21, 1'b1);
    step(1'b0, 8'h22, 1'b1, 8'h04, 1'b1, 8'h22, 1'b1);
    // One-edge reset with 0x23 on the input: everything in flight is dropped.
    step(1'b1, 8'h23, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

    // Post-release words emerge four edges later.
    for (int k = 0; k < 6; k++) begin
      ib = 8'(8'h30 + k);
      if (k < 3) step(1'b0, ib, 1'b1, 8'h00, 1'b0, ib, 1'b1);
      else       step(1'b0, ib, 1'b1, 8'(8'h30 + k - 3), 1'b1, ib, 1'b1);
    end

    done = 1'b1;
    wait (mon_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: after every edge, pop the expected outputs and compare.
  initial begin
    logic [8:0] e4, e1;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp4_q.size() > 0) begin
        e4 = exp4_q.pop_front();
        checks++;
        if ({ocontrol4, odata4} !== e4) begin
          errors++;
          $display("FAIL pipe4 cyc %0d: got ctrl=%b data=%h, want ctrl=%b data=%h",
                   cyc, ocontrol4, odata4, e4[8], e4[7:0]);
        end
      end
      if (exp1_q.size() > 0) begin
        e1 = exp1_q.pop_front();
        checks++;
        if ({ocontrol1, odata1} !== e1) begin
          errors++;
          $display("FAIL pipe1 cyc %0d: got ctrl=%b data=%h, want ctrl=%b data=%h",
                   cyc, ocontrol1, odata1, e1[8], e1[7:0]);
        end
      end
    end
    checks++;
    if (exp4_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0",
               exp4_q.size(), exp1_q.size());
    end
    mon_done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
